load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and legality helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_illegal(input logic ld, input logic st, input logic [2:0] f3);
        logic bad;
        bad = (ld == st);
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
            bad = 1'b1;
        end
        if (st && (f3 >= 3'd3)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Only called for legal ops, so func3[1:0] is the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'd1 && off[0]) begin
            bad = 1'b1;
        end
        if (f3[1:0] == 2'd2 && off != 2'd0) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane placement for stores and lane select/extension for loads
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = load_word >> {offset, 3'b000};

        case (func3[1:0])
            2'd0: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            2'd1: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << offset;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase

        case (func3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = load_word;
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage with single-outstanding memory port and timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        func3,
    input  logic [31:0]       rs1_value,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs2_value,
    input  logic [4:0]        rd_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic [4:0]        rd_addr_out,
    output logic              rd_we,
    output logic [1:0]        err
);

    lsu_state_e        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       ea;
    logic [15:0]       cnt_inc;
    logic [2:0]        align_func3;
    logic [1:0]        align_off;
    logic [31:0]       align_wdata;
    logic [3:0]        align_wstrb;
    logic [31:0]       align_load;
    logic              in_req;
    logic              in_done;

    assign ea      = rs1_value + imm;
    assign cnt_inc = cnt_q + 16'd1;

    // One aligner serves both paths: live inputs while idle (store encode), captured op in RESP.
    assign align_func3 = (state_q == ST_IDLE) ? func3    : func3_q;
    assign align_off   = (state_q == ST_IDLE) ? ea[1:0]  : off_q;

    lsu_lane_align u_align (
        .func3      (align_func3),
        .offset     (align_off),
        .store_data (rs2_value),
        .load_word  (rdata_q),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .load_data  (align_load)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        we_d        = we_q;
        func3_d     = func3_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rd_d        = rd_q;
        rdata_d     = rdata_q;
        load_data_d = load_data_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_load_d   = is_load;
                    we_d        = is_store;
                    func3_d     = func3;
                    off_d       = ea[1:0];
                    addr_d      = ADDR_W'({ea[31:2], 2'b00});
                    wdata_d     = is_store ? align_wdata : 32'd0;
                    wstrb_d     = is_store ? align_wstrb : 4'd0;
                    rd_d        = rd_addr;
                    load_data_d = 32'd0;
                    cnt_d       = 16'd0;
                    if (is_illegal(is_load, is_store, func3)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_DONE;
                    end else if (is_misaligned(func3, ea[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 16'(TIMEOUT_CYCLES)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RESP: begin
                if (is_load_q) begin
                    load_data_d = align_load;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            is_load_q   <= 1'b0;
            we_q        <= 1'b0;
            func3_q     <= 3'd0;
            off_q       <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rd_q        <= 5'd0;
            rdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            we_q        <= we_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    // Outputs are gated by state so an asynchronous reset clears them in the same cycle.
    assign in_req  = (state_q == ST_REQ);
    assign in_done = (state_q == ST_DONE);

    assign busy        = (state_q != ST_IDLE);
    assign mem_req     = in_req;
    assign mem_we      = in_req & we_q;
    assign mem_addr    = in_req ? addr_q  : '0;
    assign mem_wdata   = in_req ? wdata_q : 32'd0;
    assign mem_wstrb   = in_req ? wstrb_q : 4'd0;
    assign done        = in_done;
    assign load_data   = in_done ? load_data_q : 32'd0;
    assign rd_addr_out = in_done ? rd_q : 5'd0;
    assign rd_we       = in_done & is_load_q & (err_q == ERR_OK);
    assign err         = in_done ? err_q : ERR_OK;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] rs1_value = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs2_value = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [4:0]  rd_addr_out;
    logic        rd_we;
    logic [1:0]  err;

    load_store_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .func3(func3), .rs1_value(rs1_value), .imm(imm), .rs2_value(rs2_value),
        .rd_addr(rd_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .load_data(load_data),
        .rd_addr_out(rd_addr_out), .rd_we(rd_we), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected outcome of the op in flight, as a timeline relative to the start cycle
    logic        active = 1'b0;
    int          cyc = 0;
    int          req_end = 0;
    int          done_cyc = 0;
    int          op_w = 0;
    logic [31:0] op_rdata = 32'd0;
    logic        e_store = 1'b0;
    logic [1:0]  e_err = 2'd0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [3:0]  e_wstrb = 4'd0;
    logic [31:0] e_ld = 32'd0;
    logic        e_rdwe = 1'b0;
    logic [4:0]  e_rd = 5'd0;

    // What the DUT was seen doing during the op, for the directed literal checks
    int          o_req_cnt = 0;
    int          o_done_cyc = -1;
    logic [31:0] o_addr = 32'd0;
    logic [31:0] o_wdata = 32'd0;
    logic [3:0]  o_wstrb = 4'd0;
    logic        o_we = 1'b0;
    logic [1:0]  o_err = 2'd0;
    logic [31:0] o_ld = 32'd0;
    logic        o_rdwe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int o, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * o)) & 32'h0000_00FF;
        h = (w >> (8 * o)) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input int o);
        if (f3 == 3'd0) return 4'(1 << o);
        if (f3 == 3'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    // Compare process: every cycle, DUT outputs against the op timeline
    initial begin
        logic req_e, busy_e, done_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_mem_req", 32'(mem_req), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_load_data", load_data, 0);
                chk("rst_rd_addr_out", 32'(rd_addr_out), 0);
                chk("rst_rd_we", 32'(rd_we), 0);
                chk("rst_err", 32'(err), 0);
            end else if (active) begin
                req_e  = (cyc >= 1) && (cyc <= req_end);
                busy_e = (cyc >= 1) && (cyc <= done_cyc);
                done_e = (cyc == done_cyc);
                chk("busy", 32'(busy), 32'(busy_e));
                chk("mem_req", 32'(mem_req), 32'(req_e));
                chk("done", 32'(done), 32'(done_e));
                if (req_e) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_we", 32'(mem_we), 32'(e_store));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
                    if (e_store) chk("mem_wdata", mem_wdata, e_wdata);
                end
                if (done_e) begin
                    chk("err", 32'(err), 32'(e_err));
                    chk("load_data", load_data, e_ld);
                    chk("rd_addr_out", 32'(rd_addr_out), 32'(e_rd));
                    chk("rd_we", 32'(rd_we), 32'(e_rdwe));
                end else begin
                    chk("rd_we_idle", 32'(rd_we), 0);
                end
                if (mem_req) begin
                    o_req_cnt++;
                    o_addr  = mem_addr;
                    o_wdata = mem_wdata;
                    o_wstrb = mem_wstrb;
                    o_we    = mem_we;
                end
                if (done) begin
                    o_done_cyc = cyc;
                    o_err      = err;
                    o_ld       = load_data;
                    o_rdwe     = rd_we;
                end
                if (cyc >= done_cyc) active = 1'b0;
                cyc++;
            end else begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_mem_req", 32'(mem_req), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_rd_we", 32'(rd_we), 0);
            end
        end
    end

    // Memory responder: ready on the (w+1)-th request cycle, stray ready pulses outside REQ
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (active && cyc >= 1 && cyc <= req_end) begin
                mem_ready = (cyc == op_w + 1);
                mem_rdata = mem_ready ? op_rdata : $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    task automatic scramble_inputs();
        is_load   = 1'($urandom);
        is_store  = ~is_load;
        func3     = 3'($urandom_range(0, 2));
        rs1_value = $urandom & 32'hFFFF_FFFC;
        imm       = 32'd0;
        rs2_value = $urandom;
        rd_addr   = 5'($urandom);
    endtask

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 after done
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] im, input logic [31:0] rs2,
                          input logic [4:0] rd, input int w, input logic [31:0] rdata,
                          input int junk_at);
        logic [31:0] ea;
        int o;
        logic ill, mis;
        int n;
        ea  = rs1 + im;
        o   = int'(ea & 32'd3);
        ill = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 3);
        mis = !ill && ((f3[1:0] == 2'd1 && (o % 2) != 0) || (f3[1:0] == 2'd2 && o != 0));
        if (ill || mis) begin
            e_err = ill ? 2'b11 : 2'b01; req_end = 0; done_cyc = 1;
        end else if (w < T) begin
            e_err = 2'b00; req_end = w + 1; done_cyc = w + 3;
        end else begin
            e_err = 2'b10; req_end = T; done_cyc = T + 1;
        end
        e_store  = st;
        e_addr   = ea & 32'hFFFF_FFFC;
        e_wdata  = ref_wdata(f3, rs2);
        e_wstrb  = st ? ref_wstrb(f3, o) : 4'd0;
        e_rdwe   = ld && !st && e_err == 2'b00;
        e_ld     = e_rdwe ? ref_load(f3, o, rdata) : 32'd0;
        e_rd     = rd;
        op_w     = w;
        op_rdata = rdata;
        o_req_cnt = 0; o_done_cyc = -1;
        is_load = ld; is_store = st; func3 = f3; rs1_value = rs1; imm = im;
        rs2_value = rs2; rd_addr = rd; start = 1'b1;
        cyc = 0; active = 1'b1;
        n = 0;
        while (active && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start = (junk_at != 0 && cyc == junk_at);
            scramble_inputs();
        end
        start = 1'b0;
        if (active) begin
            chk("op_completes_within_bound", 32'(active), 0);
            active = 1'b0;
        end
    endtask

    initial begin
        logic ld, st;
        logic [2:0] f3;
        logic [31:0] rs1, im, ea;
        int sz, n;

        // Pin the reference model with hand-computed values
        chk("model_lb", ref_load(3'd0, 3, 32'h8011_2233), 32'hFFFF_FF80);
        chk("model_lbu", ref_load(3'd4, 3, 32'h8011_2233), 32'h0000_0080);
        chk("model_lhu", ref_load(3'd5, 2, 32'h8001_1234), 32'h0000_8001);
        chk("model_sh_wdata", ref_wdata(3'd1, 32'h0000_ABCD), 32'hABCD_ABCD);
        chk("model_sh_wstrb", 32'(ref_wstrb(3'd1, 2)), 32'hC);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(1, 0, 3'd2, 32'h100, 32'd4, 32'd0, 5'd5, 3, 32'hDEAD_BEEF, 0);
        chk("lw_addr", o_addr, 32'h104);
        chk("lw_wstrb", 32'(o_wstrb), 0);
        chk("lw_we", 32'(o_we), 0);
        chk("lw_done_cycle", 32'(o_done_cyc), 6);
        chk("lw_req_cycles", 32'(o_req_cnt), 4);
        chk("lw_data", o_ld, 32'hDEAD_BEEF);
        chk("lw_rd_we", 32'(o_rdwe), 1);
        chk("lw_err", 32'(o_err), 0);

        run_op(1, 0, 3'd0, 32'h200, 32'd3, 32'd0, 5'd7, 0, 32'h8011_2233, 0);
        chk("lb_data", o_ld, 32'hFFFF_FF80);
        chk("lb_done_cycle", 32'(o_done_cyc), 3);
        run_op(1, 0, 3'd4, 32'h200, 32'd3, 32'd0, 5'd7, 1, 32'h8011_2233, 0);
        chk("lbu_data", o_ld, 32'h0000_0080);

        run_op(0, 1, 3'd1, 32'h100, 32'd2, 32'h0000_ABCD, 5'd0, 0, 32'd0, 0);
        chk("sh_addr", o_addr, 32'h100);
        chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", 32'(o_wstrb), 32'hC);
        chk("sh_we", 32'(o_we), 1);
        chk("sh_rd_we", 32'(o_rdwe), 0);

        run_op(1, 0, 3'd2, 32'h100, 32'd1, 32'd0, 5'd3, 0, 32'd0, 0);
        chk("mis_req_cycles", 32'(o_req_cnt), 0);
        chk("mis_done_cycle", 32'(o_done_cyc), 1);
        chk("mis_err", 32'(o_err), 1);
        chk("mis_rd_we", 32'(o_rdwe), 0);

        run_op(1, 0, 3'd2, 32'h400, 32'd0, 32'd0, 5'd9, 50, 32'h1234_5678, 3);
        chk("to_req_cycles", 32'(o_req_cnt), T);
        chk("to_err", 32'(o_err), 2);
        chk("to_done_cycle", 32'(o_done_cyc), T + 1);

        run_op(1, 0, 3'd2, 32'h400, 32'd0, 32'd0, 5'd9, T - 1, 32'h1234_5678, 0);
        chk("last_cycle_ready_err", 32'(o_err), 0);
        chk("last_cycle_ready_done", 32'(o_done_cyc), T + 2);

        // Reset while the request is outstanding
        ld = 1'b1;
        is_load = 1'b1; is_store = 1'b0; func3 = 3'd2; rs1_value = 32'h800; imm = 32'd0;
        op_w = 50; req_end = T; done_cyc = T + 1; e_store = 1'b0; e_addr = 32'h800;
        e_wstrb = 4'd0; e_err = 2'b10; e_ld = 32'd0; e_rdwe = 1'b0; e_rd = 5'd0; rd_addr = 5'd0;
        start = 1'b1; cyc = 0; active = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (cyc != 3 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        rst = 1'b1; active = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 1, 3'd2, 32'h300, 32'd8, 32'hCAFE_F00D, 5'd1, 0, 32'd0, 0);
        chk("sw_after_rst_err", 32'(o_err), 0);
        chk("sw_after_rst_done", 32'(o_done_cyc), 3);
        chk("sw_after_rst_wdata", o_wdata, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 9);
            ld = (n == 0) || (n >= 2 && n < 6);
            st = (n == 0) || (n >= 6);
            if ($urandom_range(0, 9) < 7) begin
                f3 = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
                if (f3 == 3'd3) f3 = 3'd5;
            end else begin
                f3 = 3'($urandom);
            end
            rs1 = $urandom;
            im  = 32'($urandom_range(0, 4095)) - 32'd2048;
            sz  = int'(f3[1:0]);
            if ($urandom_range(0, 3) != 0) begin
                ea = rs1 + im;
                im = im - (ea & 32'd3);
                if (sz == 0) im = im + 32'($urandom_range(0, 3));
                if (sz == 1) im = im + 32'($urandom_range(0, 1) * 2);
            end
            run_op(ld, st, f3, rs1, im, $urandom, 5'($urandom), $urandom_range(0, 10),
                   $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
